display_read_server: RTL and testbench

- Memory-side responder for the display controller's back-door read port inside memMux.
- Accepts cache-line read requests (readReq/RA, acknowledged by readAck) from the display DMA and forwards them to the DDR read-command arbiter.
- Returns each 256-bit cache line (8 words of {0,r,g,b}) as two 96-bit packed-pixel beats on RD/RDready.
- Bounds in-flight lines with a credit counter.

---
 rtl/display_pkg.sv | 28 ++
 rtl/display_credit_counter.sv | 38 +++
 rtl/display_read_server.sv | 129 ++++++++++++
 tb/tb_display_read_server.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display definitions: beat geometry, read-server state encoding and
// the 128-bit DDR word beat to 96-bit packed-pixel beat conversion.
package display_pkg;

  localparam int unsigned LINE_BEATS      = 2;
  localparam int unsigned PIXELS_PER_BEAT = 4;
  localparam int unsigned PIXEL_W         = 24;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BEAT_W          = PIXELS_PER_BEAT * WORD_W;
  localparam int unsigned PIX_BEAT_W      = PIXELS_PER_BEAT * PIXEL_W;
  localparam int unsigned CREDIT_W        = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Drops the top (zero) byte of each {0,r,g,b} word; pixel 0 stays lowest.
  function automatic logic [PIX_BEAT_W-1:0] pack_beat(input logic [BEAT_W-1:0] words);
    logic [PIX_BEAT_W-1:0] pix;
    pix = '0;
    for (int unsigned k = 0; k < PIXELS_PER_BEAT; k++) begin
      pix[k*PIXEL_W +: PIXEL_W] = words[k*WORD_W +: PIXEL_W];
    end
    return pix;
  endfunction

endpackage

// File: rtl/display_credit_counter.sv
// Outstanding-transaction credit counter for memMux back-door ports:
// simultaneous inc/dec cancel, decrement at zero saturates.
module display_credit_counter
  import display_pkg::*;
#(
  parameter int unsigned MAX = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [CREDIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q >= CREDIT_W'(MAX));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/display_read_server.sv
// Display back-door read responder: forwards line reads to the DDR arbiter
// and repacks returned lines into pixel beats. Option: DISPLAY_READ_ORPHAN_CHECK_EN.
module display_read_server
  import display_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ADDR_W          = 26
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  readReq,
  input  logic [ADDR_W-1:0]     RA,
  output logic                  readAck,
  output logic [PIX_BEAT_W-1:0] RD,
  output logic                  RDready,
  output logic                  memReq,
  output logic [ADDR_W-1:0]     memAddr,
  input  logic                  memGrant,
  input  logic [BEAT_W-1:0]     memRdData,
  input  logic                  memRdValid,
  output logic                  orphanErr
);

  state_e                state_q, state_d;
  logic                  readAck_q, readAck_d;
  logic                  memReq_q, memReq_d;
  logic [ADDR_W-1:0]     memAddr_q, memAddr_d;
  logic [PIX_BEAT_W-1:0] rd_q;
  logic                  rdready_q;
  logic                  beat_q;
  logic                  credit_full, credit_empty;
  logic                  accept, grant, line_done;

  assign accept    = (state_q == ST_IDLE) && readReq && !credit_full;
  assign grant     = (state_q == ST_REQ) && memGrant;
  assign line_done = memRdValid && (beat_q == 1'(LINE_BEATS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  if (grant)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    readAck_d = 1'b0;
    memReq_d  = memReq_q;
    memAddr_d = memAddr_q;
    if (accept) begin
      readAck_d = 1'b1;
      memReq_d  = 1'b1;
      memAddr_d = RA;
    end else if (grant) begin
      memReq_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readAck_q <= 1'b0;
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
    end else begin
      readAck_q <= readAck_d;
      memReq_q  <= memReq_d;
      memAddr_q <= memAddr_d;
    end
  end

  // Return path: fixed one-cycle latency, no buffering or backpressure.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q      <= '0;
      rdready_q <= 1'b0;
      beat_q    <= 1'b0;
    end else begin
      rdready_q <= memRdValid;
      if (memRdValid) begin
        rd_q   <= pack_beat(memRdData);
        beat_q <= ~beat_q;
      end
    end
  end

  // A completion against an empty count is an orphan and must not consume a grant.
  display_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_credit (
    .clk_i   (clock),
    .rst_i   (reset),
    .inc_i   (grant),
    .dec_i   (line_done && !credit_empty),
    .full_o  (credit_full),
    .empty_o (credit_empty)
  );

`ifdef DISPLAY_READ_ORPHAN_CHECK_EN
  logic orphan_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      orphan_q <= 1'b0;
    end else if ((memRdValid && credit_empty && !beat_q) || (memGrant && !memReq_q)) begin
      orphan_q <= 1'b1;
    end
  end

  assign orphanErr = orphan_q;
`else
  assign orphanErr = 1'b0;
`endif

  assign readAck = readAck_q;
  assign memReq  = memReq_q;
  assign memAddr = memAddr_q;
  assign RD      = rd_q;
  assign RDready = rdready_q;

endmodule

// File: tb/tb_display_read_server.sv
// Bench for display_read_server: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_display_read_server;

  localparam int unsigned MAXO = 8;
  localparam int unsigned AW   = 26;
`ifdef DISPLAY_READ_ORPHAN_CHECK_EN
  localparam bit ORPH_EXP = 1'b1;
`else
  localparam bit ORPH_EXP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          readReq;
  logic [AW-1:0] RA;
  logic          readAck;
  logic [95:0]   RD;
  logic          RDready;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memGrant;
  logic [127:0]  memRdData;
  logic          memRdValid;
  logic          orphanErr;

  logic auto_grant, man_grant;
  assign memGrant = auto_grant ? memReq : man_grant;

  display_read_server #(
    .MAX_OUTSTANDING (MAXO),
    .ADDR_W          (AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .readReq    (readReq),
    .RA         (RA),
    .readAck    (readAck),
    .RD         (RD),
    .RDready    (RDready),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memGrant   (memGrant),
    .memRdData  (memRdData),
    .memRdValid (memRdValid),
    .orphanErr  (orphanErr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pixel packing written as shift/mask arithmetic.
  function automatic logic [95:0] model_pack(input logic [127:0] d);
    logic [127:0] t;
    logic [95:0]  r;
    t = d;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r = r | (96'(t & 128'hFF_FFFF) << (24 * i));
      t = t >> 32;
    end
    return r;
  endfunction

  // Reference model: pending request flag, credit count, line beat parity.
  bit          m_pending, m_beat, m_ack, m_memreq, m_rdy, m_orph;
  int          m_cnt;
  logic [AW-1:0] m_addr;
  logic [95:0] m_rd;
  bit          cmp_en = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_pending = 0; m_beat = 0; m_ack = 0; m_memreq = 0; m_rdy = 0; m_orph = 0;
      m_cnt = 0; m_addr = '0; m_rd = '0;
    end else begin
      bit gnt, done, acc;
      if (ORPH_EXP && ((memRdValid && m_cnt == 0 && !m_beat) || (memGrant && !m_memreq)))
        m_orph = 1;
      gnt  = m_pending && memGrant;
      done = memRdValid && m_beat;
      acc  = !m_pending && readReq && (m_cnt < int'(MAXO));
      m_cnt = m_cnt + (gnt ? 1 : 0) - ((done && m_cnt > 0) ? 1 : 0);
      if (gnt) m_pending = 0;
      if (acc) begin
        m_pending = 1;
        m_addr    = RA;
      end
      m_ack    = acc;
      m_memreq = m_pending;
      m_rdy    = memRdValid;
      if (memRdValid) begin
        m_rd   = model_pack(memRdData);
        m_beat = !m_beat;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("readAck",   readAck,   m_ack);
      chk("memReq",    memReq,    m_memreq);
      chk("memAddr",   memAddr,   m_addr);
      chk("RDready",   RDready,   m_rdy);
      chk("RD",        RD,        m_rd);
      chk("orphanErr", orphanErr, m_orph);
    end
  end

  int ncyc = 0, ack_cnt = 0, rdy_cnt = 0;

  task automatic cyc();
    @(negedge clock);
    ncyc++;
    if (readAck) ack_cnt++;
    if (RDready) rdy_cnt++;
  endtask

  task automatic beat(input logic [127:0] d);
    memRdValid = 1'b1;
    memRdData  = d;
    cyc();
    memRdValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, k, last, c, ack9;
    reset = 1; readReq = 0; RA = '0; auto_grant = 0; man_grant = 0;
    memRdData = '0; memRdValid = 0;
    cyc();
    cmp_en = 1;
    cyc();
    reset = 0;
    chk("rst_readAck", readAck, 0);
    chk("rst_RDready", RDready, 0);
    chk("rst_RD", RD, 0);
    chk("rst_memReq", memReq, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_orphan", orphanErr, 0);

    // Single request, grant three cycles later, one line back
    a0 = ack_cnt;
    RA = 26'h100_0000; readReq = 1;
    cyc();
    chk("t1_ack", readAck, 1);
    chk("t1_addr", memAddr, 26'h100_0000);
    readReq = 0;
    cyc(); cyc();
    man_grant = 1;
    cyc();
    man_grant = 0;
    chk("t1_memreq_drop", memReq, 0);
    cyc();
    chk("t1_ack_once", ack_cnt - a0, 1);
    r0 = rdy_cnt;
    beat({4{32'hAA33_2211}});
    beat({4{32'hAA33_2211}});
    cyc();
    chk("t1_rd", RD, {4{24'h33_2211}});
    cyc();
    chk("t1_rdy_pulses", rdy_cnt - r0, 2);

    // Back-to-back stream with immediate grant
    auto_grant = 1; RA = 26'h100_0000; readReq = 1; k = 0; last = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (readAck) begin
        chk("t2_addr", memAddr, 26'h100_0000 + k);
        if (k > 0) chk("t2_gap", ncyc - last, 2);
        last = ncyc;
        k++;
        RA = RA + 1'b1;
      end
    end
    readReq = 0;
    chk("t2_count", k, 3);
    cyc();
    auto_grant = 0;
    for (int i = 0; i < 6; i++) beat({4{32'h0102_0304 + i}});
    cyc();

    // Credit limit: eight accepts, then blocked until a line returns
    auto_grant = 1; RA = 26'h000_0100; readReq = 1; a0 = ack_cnt;
    repeat (30) begin
      cyc();
      if (readAck) RA = RA + 1'b1;
    end
    chk("t3_eight_acks", ack_cnt - a0, 8);
    beat({4{32'h0055_6677}});
    c = ncyc;
    beat({4{32'h0088_99AA}});
    ack9 = 0;
    for (int i = 0; i < 10 && ack9 == 0; i++) begin
      cyc();
      if (readAck) begin
        ack9 = ncyc;
        RA = RA + 1'b1;
      end
    end
    chk("t3_ack9_late", (ack9 >= c + 2) ? 1 : 0, 1);
    chk("t3_nine_acks", ack_cnt - a0, 9);
    readReq = 0;
    cyc();
    auto_grant = 0;

    // Simultaneous grant and completion at seven outstanding
    beat({4{32'h0011_1111}});
    beat({4{32'h0022_2222}});
    readReq = 1; a0 = ack_cnt;
    cyc();
    chk("t4_accept", readAck, 1);
    beat({4{32'h0033_3333}});
    memRdValid = 1; memRdData = {4{32'h0044_4444}}; man_grant = 1;
    cyc();
    memRdValid = 0; man_grant = 0;
    cyc();
    chk("t4_next_accept", readAck, 1);
    man_grant = 1;
    cyc();
    man_grant = 0;
    repeat (5) cyc();
    chk("t4_blocked", ack_cnt - a0, 2);
    readReq = 0;
    for (int i = 0; i < 16; i++) beat({4{32'h0100_0000 + i}});
    cyc();

    // Reset while waiting for a grant, then stale beats
    RA = 26'h3AB_CDEF; readReq = 1;
    cyc();
    readReq = 0;
    cyc();
    chk("t5_memreq_held", memReq, 1);
    reset = 1;
    cyc();
    reset = 0;
    chk("t5_memreq_reset", memReq, 0);
    a0 = ack_cnt;
    repeat (3) cyc();
    chk("t5_no_ack", ack_cnt - a0, 0);
    r0 = rdy_cnt;
    beat({4{32'h00DE_AD01}});
    beat({4{32'h00BE_EF02}});
    cyc();
    chk("t5_stale_rdy", rdy_cnt - r0, 2);
    chk("t5_orphan", orphanErr, ORPH_EXP);

    // Pack ordering
    beat({32'hFF0A_0B0C, 32'hFF0D_0E0F, 32'hFF10_1112, 32'hFF13_1415});
    chk("t6_pack", RD, 96'h0A0B0C_0D0E0F_101112_131415);
    cyc();

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
